// File: rtl/lcd_timing_pkg.sv
// Shared panel constants and helpers for the LCD timing generator.
// Defaults describe an 800x480 panel; the counter width bounds the largest legal total.
package lcd_timing_pkg;

    localparam int CNT_W     = 11;
    localparam int MAX_TOTAL = 2047;

    localparam int DEF_H_ACTIVE = 800;
    localparam int DEF_H_FRONT  = 40;
    localparam int DEF_H_SYNC   = 48;
    localparam int DEF_H_BACK   = 40;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 13;
    localparam int DEF_V_SYNC   = 3;
    localparam int DEF_V_BACK   = 29;
    localparam int DEF_TICK_DIV = 2;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One raster axis: a wrapping position counter plus registered active/sync decodes
// that are aligned with the count (decoded from the next-state value).
module lcd_axis_counter
    import lcd_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter int START  = 0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] count_o,
    output logic             wrap_o,
    output logic             active_o,
    output logic             sync_n_o
);

    localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);

    localparam logic [CNT_W-1:0] LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_LO = CNT_W'(ACTIVE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_HI = CNT_W'(ACTIVE + FRONT + SYNC);
    localparam logic [CNT_W-1:0] START_V = CNT_W'(START);

    localparam logic ACTIVE_RST = (START < ACTIVE);
    localparam logic SYNC_N_RST = !((START >= ACTIVE + FRONT) && (START < ACTIVE + FRONT + SYNC));

    if (TOTAL > MAX_TOTAL || TOTAL < 1) begin : g_bad_total
        $error("lcd_axis_counter: axis total %0d outside 1..%0d", TOTAL, MAX_TOTAL);
    end
    if (START >= TOTAL) begin : g_bad_start
        $error("lcd_axis_counter: START %0d beyond axis total %0d", START, TOTAL);
    end

    logic [CNT_W-1:0] count_q, count_d;
    logic             active_q, active_d;
    logic             sync_n_q, sync_n_d;

    always_comb begin
        wrap_o  = enable_i && (count_q == LAST);
        count_d = count_q;
        if (enable_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + ONE;
        end
        active_d = (count_d < ACT_END);
        sync_n_d = !((count_d >= SYNC_LO) && (count_d < SYNC_HI));
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q  <= START_V;
            active_q <= ACTIVE_RST;
            sync_n_q <= SYNC_N_RST;
        end else begin
            count_q  <= count_d;
            active_q <= active_d;
            sync_n_q <= sync_n_d;
        end
    end

    assign count_o  = count_q;
    assign active_o = active_q;
    assign sync_n_o = sync_n_q;

endmodule

// File: rtl/lcd_timing_generator.sv
// Parallel RGB LCD timing: pixel tick, raster counters, DE/sync decode and a pin stage
// that holds data, DE and syncs for one pixel period so they stay mutually aligned.
module lcd_timing_generator
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic        clock,
    input  logic        reset,
    output logic        lcd_tick,
    output logic        lcd_data_enable,
    output logic        lcd_next_frame,
    input  logic [7:0]  lcd_red,
    input  logic [7:0]  lcd_green,
    input  logic [7:0]  lcd_blue,
    output logic        lcd_dclk,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [7:0]  lcd_r,
    output logic [7:0]  lcd_g,
    output logic [7:0]  lcd_b,
    output logic [31:0] debug_frame_count
);

    localparam int DW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);

    localparam logic [DW-1:0]    DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [DW-1:0]    DIV_ONE  = DW'(1);
    localparam logic [DW-1:0]    DCLK_ON  = DW'(TICK_DIV / 2);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_PRE    = CNT_W'((V_ACTIVE > 0) ? V_ACTIVE - 1 : 0);

    if (TICK_DIV < 2) begin : g_bad_div
        $error("lcd_timing_generator: TICK_DIV must be at least 2, got %0d", TICK_DIV);
    end

    logic [DW-1:0]    div_q, div_d;
    logic             tick;
    logic             dclk_q, dclk_d;
    logic             next_frame_q, next_frame_d;
    logic [31:0]      frame_cnt_q;

    logic [CNT_W-1:0] h_count, v_count;
    logic             h_wrap, v_wrap;
    logic             h_active, v_active;
    logic             h_sync_n, v_sync_n;
    logic             data_enable;
    logic             v_pre;

    logic             de_pin_q, hs_pin_q, vs_pin_q;
    rgb_t             pix_in, pix_q;

    assign tick        = (div_q == DIV_LAST);
    assign data_enable = h_active && v_active;
    assign pix_in      = '{r: lcd_red, g: lcd_green, b: lcd_blue};

    lcd_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .START  (0)
    ) u_h_axis (
        .clock_i  (clock),
        .reset_i  (reset),
        .enable_i (tick),
        .count_o  (h_count),
        .wrap_o   (h_wrap),
        .active_o (h_active),
        .sync_n_o (h_sync_n)
    );

    // Reset parks v at the first blanking line so the streamer gets a full blanking to prefill.
    lcd_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .START  (V_ACTIVE)
    ) u_v_axis (
        .clock_i  (clock),
        .reset_i  (reset),
        .enable_i (h_wrap),
        .count_o  (v_count),
        .wrap_o   (v_wrap),
        .active_o (v_active),
        .sync_n_o (v_sync_n)
    );

    always_comb begin
        div_d        = tick ? '0 : div_q + DIV_ONE;
        dclk_d       = (div_d >= DCLK_ON);
        v_pre        = (V_ACTIVE == 0) ? v_wrap : (v_count == V_PRE);
        // Last pixel of the last active line: the counters load (0, V_ACTIVE) at this edge.
        next_frame_d = tick && (h_count == H_LAST) && v_pre;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            div_q        <= '0;
            dclk_q       <= 1'b0;
            next_frame_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            div_q        <= div_d;
            dclk_q       <= dclk_d;
            next_frame_q <= next_frame_d;
            if (next_frame_q) begin
                frame_cnt_q <= frame_cnt_q + 32'd1;
            end
        end
    end

    // Pin stage samples once per pixel, so pins trail the counters by exactly one pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            de_pin_q <= 1'b0;
            hs_pin_q <= 1'b1;
            vs_pin_q <= 1'b1;
            pix_q    <= '0;
        end else if (tick) begin
            de_pin_q <= data_enable;
            hs_pin_q <= h_sync_n;
            vs_pin_q <= v_sync_n;
            pix_q    <= data_enable ? pix_in : '0;
        end
    end

    assign lcd_tick          = tick;
    assign lcd_data_enable   = data_enable;
    assign lcd_next_frame    = next_frame_q;
    assign lcd_dclk          = dclk_q;
    assign lcd_hs            = hs_pin_q;
    assign lcd_vs            = vs_pin_q;
    assign lcd_de            = de_pin_q;
    assign lcd_r             = pix_q.r;
    assign lcd_g             = pix_q.g;
    assign lcd_b             = pix_q.b;
    assign debug_frame_count = frame_cnt_q;

endmodule

// File: tb/tb_lcd_timing_generator.sv
// Randomized bench for lcd_timing_generator: two small-panel instances (TICK_DIV 2 and 4)
// checked every cycle against a raster-position model computed from elapsed cycles.
module tb_lcd_timing_generator;

    localparam int HA = 4, HF = 1, HS = 1, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int NI = 2;
    localparam int NCYC = 1400;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] red = 8'd0, green = 8'd0, blue = 8'd0;

    logic        tick_w [NI];
    logic        den_w  [NI];
    logic        nf_w   [NI];
    logic        dclk_w [NI];
    logic        hs_w   [NI];
    logic        vs_w   [NI];
    logic        de_w   [NI];
    logic [7:0]  r_w    [NI];
    logic [7:0]  g_w    [NI];
    logic [7:0]  b_w    [NI];
    logic [31:0] fc_w   [NI];

    always #5 clock = ~clock;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        lcd_timing_generator #(
            .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
            .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
            .TICK_DIV (2 * (gi + 1))
        ) u_dut (
            .clock             (clock),
            .reset             (reset),
            .lcd_tick          (tick_w[gi]),
            .lcd_data_enable   (den_w[gi]),
            .lcd_next_frame    (nf_w[gi]),
            .lcd_red           (red),
            .lcd_green         (green),
            .lcd_blue          (blue),
            .lcd_dclk          (dclk_w[gi]),
            .lcd_hs            (hs_w[gi]),
            .lcd_vs            (vs_w[gi]),
            .lcd_de            (de_w[gi]),
            .lcd_r             (r_w[gi]),
            .lcd_g             (g_w[gi]),
            .lcd_b             (b_w[gi]),
            .debug_frame_count (fc_w[gi])
        );
    end

    int n_chk = 0;
    int n_err = 0;
    int now   = 0;

    // Reference model state, per instance
    int         cyc     [NI];
    int         fcnt    [NI];
    int         last_nf [NI];
    int         de_cnt  [NI];
    logic       pin_de  [NI];
    logic       pin_hs  [NI];
    logic       pin_vs  [NI];
    logic [7:0] pin_r   [NI];
    logic [7:0] pin_g   [NI];
    logic [7:0] pin_b   [NI];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, now, got, exp);
        end
    endtask

    // Raster position after c cycles out of reset, which starts at pixel (0, VA).
    function automatic void pos(input int c, input int td, output int dv, output int h, output int v);
        int lin;
        dv  = c % td;
        lin = (VA * HT + c / td) % (HT * VT);
        h   = lin % HT;
        v   = lin / HT;
    endfunction

    function automatic logic hs_raw(input int h);
        return !((h >= HA + HF) && (h < HA + HF + HS));
    endfunction

    function automatic logic vs_raw(input int v);
        return !((v >= VA + VF) && (v < VA + VF + VS));
    endfunction

    task automatic check_cycle(input int i);
        int   td, dv, h, v;
        logic exp_de, exp_nf;
        td     = 2 * (i + 1);
        pos(cyc[i], td, dv, h, v);
        exp_de = (h < HA) && (v < VA);
        exp_nf = (cyc[i] > 0) && (dv == 0) && (h == 0) && (v == VA);
        chk($sformatf("i%0d_tick", i),  32'(tick_w[i]), 32'(dv == td - 1));
        chk($sformatf("i%0d_den", i),   32'(den_w[i]),  32'(exp_de));
        chk($sformatf("i%0d_nf", i),    32'(nf_w[i]),   32'(exp_nf));
        chk($sformatf("i%0d_dclk", i),  32'(dclk_w[i]), 32'(dv >= td / 2));
        chk($sformatf("i%0d_hs", i),    32'(hs_w[i]),   32'(pin_hs[i]));
        chk($sformatf("i%0d_vs", i),    32'(vs_w[i]),   32'(pin_vs[i]));
        chk($sformatf("i%0d_de", i),    32'(de_w[i]),   32'(pin_de[i]));
        chk($sformatf("i%0d_r", i),     32'(r_w[i]),    32'(pin_r[i]));
        chk($sformatf("i%0d_g", i),     32'(g_w[i]),    32'(pin_g[i]));
        chk($sformatf("i%0d_b", i),     32'(b_w[i]),    32'(pin_b[i]));
        chk($sformatf("i%0d_fcnt", i),  fc_w[i],        32'(fcnt[i]));
        if (nf_w[i] === 1'b1) begin
            if (last_nf[i] < 0)
                chk($sformatf("i%0d_first_nf", i), 32'(cyc[i]), 32'(HT * VT * td));
            else
                chk($sformatf("i%0d_frame_len", i), 32'(now - last_nf[i]), 32'(HT * VT * td));
            chk($sformatf("i%0d_de_per_frame", i), 32'(de_cnt[i]), 32'(HA * VA * td));
            last_nf[i] = now;
            de_cnt[i]  = 0;
        end
        if (de_w[i] === 1'b1) de_cnt[i]++;
    endtask

    task automatic advance(input int i, input bit rst);
        int   td, dv, h, v;
        logic de;
        td = 2 * (i + 1);
        if (rst) begin
            cyc[i]     = 0;
            fcnt[i]    = 0;
            last_nf[i] = -1;
            de_cnt[i]  = 0;
            pin_de[i]  = 1'b0;
            pin_hs[i]  = 1'b1;
            pin_vs[i]  = 1'b1;
            pin_r[i]   = 8'd0;
            pin_g[i]   = 8'd0;
            pin_b[i]   = 8'd0;
        end else begin
            pos(cyc[i], td, dv, h, v);
            de = (h < HA) && (v < VA);
            if (dv == td - 1) begin
                pin_de[i] = de;
                pin_hs[i] = hs_raw(h);
                pin_vs[i] = vs_raw(v);
                pin_r[i]  = de ? red   : 8'd0;
                pin_g[i]  = de ? green : 8'd0;
                pin_b[i]  = de ? blue  : 8'd0;
            end
            if ((cyc[i] > 0) && (dv == 0) && (h == 0) && (v == VA)) fcnt[i]++;
            cyc[i]++;
        end
    endtask

    initial begin
        bit rst_next;
        bit mid_done;
        int dv0, h0, v0;
        mid_done = 1'b0;
        reset    = 1'b1;
        @(posedge clock);
        for (int i = 0; i < NI; i++) advance(i, 1'b1);
        for (int n = 0; n < NCYC; n++) begin
            @(negedge clock);
            now = n;
            for (int i = 0; i < NI; i++) check_cycle(i);
            rst_next = (n < 2);
            pos(cyc[0], 2, dv0, h0, v0);
            // Single-cycle reset in the middle of an active line of the TICK_DIV=2 instance
            if (!mid_done && n >= 400 && h0 == 2 && v0 == 0) begin
                rst_next = 1'b1;
                mid_done = 1'b1;
            end
            if (n >= 800 && $urandom_range(0, 199) == 0) rst_next = 1'b1;
            reset = rst_next;
            red   = 8'($urandom_range(1, 255));
            green = 8'($urandom_range(1, 255));
            blue  = 8'($urandom_range(1, 255));
            for (int i = 0; i < NI; i++) advance(i, rst_next);
        end
        chk("mid_line_reset_hit", 32'(mid_done), 32'd1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
